// File: rtl/key_debounce_pulse_if.sv
// key_debounce_pulse_if: raw key inputs and conditioned key outputs for key_debounce_pulse
interface key_debounce_pulse_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key_n;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  modport master (output key_n, input key_level, key_press, key_release);
  modport slave (input key_n, output key_level, key_press, key_release);
endinterface

// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse: sync, debounce and edge-detect active-low keys; define AUTO_REPEAT_EN for held-key repeat pulses
module key_debounce_pulse #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input logic                 CLOCK_50,
  input logic                 RESET_N,
  key_debounce_pulse_if.slave kif
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // The transition out of UP already counts as the first stable sample,
  // so acceptance happens on the DEBOUNCE_CYCLES-th consecutive stable sample.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);
  typedef enum logic [1:0] {UP, WAIT_DN, DOWN, WAIT_UP} state_t;
  logic [NUM_KEYS-1:0] level_v, press_v, release_v;
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic [1:0] sync_q;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic level_q, level_d, press_q, press_d, release_q, release_d;
    logic s, accept_dn, accept_up, rep_fire;
    assign s = ~sync_q[1];
    // two-flop synchroniser, idles at released
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) sync_q <= 2'b11;
      else sync_q <= {sync_q[0], kif.key_n[k]};
    end
    // debounce state, counter and registered outputs
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        state_q   <= UP;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end
    // next-state: any sample disagreeing with the pending level restarts the debounce
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      accept_dn = 1'b0;
      accept_up = 1'b0;
      case (state_q)
        UP: begin
          state_d = s ? WAIT_DN : UP;
          cnt_d   = '0;
        end
        WAIT_DN: begin
          accept_dn = s && cnt_q == CNT_LAST;
          state_d   = !s ? UP : accept_dn ? DOWN : WAIT_DN;
          cnt_d     = (s && !accept_dn) ? cnt_q + 1'b1 : cnt_q;
        end
        DOWN: begin
          state_d = s ? DOWN : WAIT_UP;
          cnt_d   = '0;
        end
        default: begin
          accept_up = !s && cnt_q == CNT_LAST;
          state_d   = s ? DOWN : accept_up ? UP : WAIT_UP;
          cnt_d     = (!s && !accept_up) ? cnt_q + 1'b1 : cnt_q;
        end
      endcase
      level_d   = accept_dn ? 1'b1 : accept_up ? 1'b0 : level_q;
      press_d   = accept_dn | rep_fire;
      release_d = accept_up;
    end
`ifdef AUTO_REPEAT_EN
    localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RMAX + 1);
    logic [RW-1:0] rcnt_q, rcnt_d, rnext, rtarget;
    logic rep_q, rep_d, held;
    assign held    = (state_q == DOWN || state_q == WAIT_UP) && !accept_up;
    assign rnext   = rcnt_q + 1'b1;
    assign rtarget = rep_q ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY);
    // repeat timer: first target is the initial delay, then the period; idle outside the held states
    always_comb begin
      rep_fire = held && rnext == rtarget;
      rcnt_d   = (held && !rep_fire) ? rnext : '0;
      rep_d    = held && (rep_q || rep_fire);
    end
    // repeat timer registers
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        rcnt_q <= '0;
        rep_q  <= 1'b0;
      end else begin
        rcnt_q <= rcnt_d;
        rep_q  <= rep_d;
      end
    end
`else
    assign rep_fire = 1'b0;
`endif
    assign level_v[k]   = level_q;
    assign press_v[k]   = press_q;
    assign release_v[k] = release_q;
  end
  assign kif.key_level   = level_v;
  assign kif.key_press   = press_v;
  assign kif.key_release = release_v;
endmodule

// File: tb/tb_key_debounce_pulse.sv
// tb_key_debounce_pulse: directed stimulus with a stable-run model checked every cycle
module tb_key_debounce_pulse;
  localparam int NK  = 4;
  localparam int DEB = 8;
  localparam int RD  = 20;
  localparam int RP  = 5;
`ifdef AUTO_REPEAT_EN
  localparam logic REP = 1'b1;
`else
  localparam logic REP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  key_debounce_pulse_if #(.NUM_KEYS(NK)) kif ();
  key_debounce_pulse #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .kif(kif)
  );
  always #5 clk = ~clk;
  logic [NK-1:0] h0 = '1, h1 = '1;
  logic [NK-1:0] m_level = '0, m_press = '0, m_release = '0;
  int run [NK];
  int acc [NK];
  function automatic logic rep_due(logic lvl, int d);
    if (REP) return lvl && (d == RD || (d > RD && (d - RD) % RP == 0));
    return 1'b0;
  endfunction
  // model: a key flips once its synchronised value has disagreed with the level for DEB consecutive edges
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h0 <= '1;
      h1 <= '1;
      m_level <= '0;
      m_press <= '0;
      m_release <= '0;
      for (int i = 0; i < NK; i++) begin
        run[i] <= 0;
        acc[i] <= 0;
      end
    end else begin
      cyc <= cyc + 1;
      h0 <= kif.key_n;
      h1 <= h0;
      for (int i = 0; i < NK; i++) begin
        if ((~h1[i]) != m_level[i] && run[i] + 1 == DEB) begin
          run[i] <= 0;
          m_level[i] <= ~m_level[i];
          m_press[i] <= ~m_level[i];
          m_release[i] <= m_level[i];
          acc[i] <= cyc;
        end else begin
          run[i] <= ((~h1[i]) != m_level[i]) ? run[i] + 1 : 0;
          m_release[i] <= 1'b0;
          m_press[i] <= rep_due(m_level[i], cyc - acc[i]);
        end
      end
    end
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask
  // every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("model_level", 32'(kif.key_level), 32'(m_level));
    chk("model_press", 32'(kif.key_press), 32'(m_press));
    chk("model_release", 32'(kif.key_release), 32'(m_release));
    chk("press_release_overlap", 32'(kif.key_press & kif.key_release), 32'd0);
  end
  task automatic tick(int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  initial begin
    kif.key_n = '1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_level", 32'(kif.key_level), 32'd0);
    chk("reset_press", 32'(kif.key_press), 32'd0);
    tick(3);
    @(negedge clk) rst_n = 1'b1;
    tick(3);
    // 1: single press accepted 10 edges after the first low sample
    @(negedge clk) kif.key_n[0] = 1'b0;
    tick(9);
    chk("t1_press_early", 32'(kif.key_press), 32'd0);
    tick(1);
    chk("t1_press", 32'(kif.key_press), 32'h1);
    chk("t1_level", 32'(kif.key_level), 32'h1);
    tick(1);
    chk("t1_press_end", 32'(kif.key_press), 32'd0);
    // 2: 5-cycle bounce is rejected
    @(negedge clk) kif.key_n[1] = 1'b0;
    repeat (5) @(negedge clk);
    kif.key_n[1] = 1'b1;
    tick(15);
    chk("t2_level", 32'(kif.key_level), 32'h1);
    // 3: press then release on key 2
    @(negedge clk) kif.key_n[2] = 1'b0;
    tick(10);
    chk("t3_press", 32'(kif.key_press), 32'h4);
    chk("t3_level", 32'(kif.key_level), 32'h5);
    @(negedge clk) kif.key_n[2] = 1'b1;
    tick(9);
    chk("t3_release_early", 32'(kif.key_release), 32'd0);
    tick(1);
    chk("t3_release", 32'(kif.key_release), 32'h4);
    chk("t3_level_after", 32'(kif.key_level), 32'h1);
    // 4: reset mid-debounce of key 1 clears outputs asynchronously
    @(negedge clk) kif.key_n[1] = 1'b0;
    tick(6);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_async_level", 32'(kif.key_level), 32'd0);
    tick(2);
    @(negedge clk) rst_n = 1'b1;
    tick(9);
    chk("t4_press_early", 32'(kif.key_press), 32'd0);
    tick(1);
    chk("t4_press", 32'(kif.key_press), 32'h3);
    // 5: keys 0 and 3 pressed on the same edge
    @(negedge clk) kif.key_n = '1;
    tick(15);
    chk("t5_released", 32'(kif.key_level), 32'd0);
    @(negedge clk) kif.key_n = 4'b0110;
    tick(10);
    chk("t5_press", 32'(kif.key_press), 32'h9);
    // 6: key 0 held; repeats only when auto-repeat is built in
    @(negedge clk) kif.key_n[3] = 1'b1;
    tick(20);
    chk("t6_repeat1", 32'(kif.key_press[0]), 32'(REP));
    tick(5);
    chk("t6_repeat2", 32'(kif.key_press[0]), 32'(REP));
    chk("t6_level", 32'(kif.key_level), 32'h1);
    tick(30);
    @(negedge clk) kif.key_n[0] = 1'b1;
    tick(20);
    chk("t6_final_level", 32'(kif.key_level), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
